unit_control_mc: RTL and testbench

Parametrised multicycle control unit for the processor datapath. It sequences each instruction through IF/ID/EX/MEM/WB with ready handshakes to instruction and data memory. It decodes `type`/`op` into a latched control word and drives the write enables and mux selects of PC, IR, register bank, flag register and data memory. Compared with the fixed four-phase unit, it adds wait states, a memory timeout fault, conditional PC write, illegal-opcode detection and a retire pulse.

---
 rtl/unit_control_mc_if.sv | 41 ++++
 rtl/unit_control_mc.sv | 188 ++++++++++++++++++
 tb/tb_unit_control_mc.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unit_control_mc_if.sv
// Control/handshake bundle between the multicycle control unit and the datapath and memories.
// The instruction-class field is ins_type because "type" is a reserved word in SystemVerilog.
interface unit_control_mc_if #(
    parameter int unsigned OP_W = 5,
    parameter int unsigned TF_W = 3,
    parameter int unsigned RF_W = 3
);
    logic [2:0]      ins_type;
    logic [OP_W-1:0] op;
    logic            im_ready;
    logic            dm_ready;
    logic            tf_true;

    logic [OP_W-1:0] OP_ALU;
    logic [TF_W-1:0] OP_TF;
    logic            OP_SE;
    logic            W_PC;
    logic            S_MXPC;
    logic            W_IM;
    logic            W_DM;
    logic            R_DM;
    logic            W_RB;
    logic [RF_W-1:0] W_RF;
    logic [1:0]      S_MXRB;
    logic            S_MXSE;
    logic            illegal;
    logic            fault;
    logic            retire;

    modport master (
        input  ins_type, op, im_ready, dm_ready, tf_true,
        output OP_ALU, OP_TF, OP_SE, W_PC, S_MXPC, W_IM, W_DM, R_DM,
               W_RB, W_RF, S_MXRB, S_MXSE, illegal, fault, retire
    );

    modport slave (
        output ins_type, op, im_ready, dm_ready, tf_true,
        input  OP_ALU, OP_TF, OP_SE, W_PC, S_MXPC, W_IM, W_DM, R_DM,
               W_RB, W_RF, S_MXRB, S_MXSE, illegal, fault, retire
    );
endinterface

// File: rtl/unit_control_mc.sv
// Multicycle control unit: IF/ID/EX/MEM/WB sequencing with memory wait states,
// a sticky timeout fault, conditional PC write on branches and illegal-type detection.
module unit_control_mc #(
    parameter int unsigned     OP_W    = 5,
    parameter int unsigned     TF_W    = 3,
    parameter int unsigned     RF_W    = 3,
    parameter int unsigned     TIMEOUT = 15,
    parameter logic [TF_W-1:0] LINK_TF = TF_W'(3'b011)
) (
    input logic              CLK,
    input logic              RESET,
    unit_control_mc_if.master bus
);
    localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StFault} state_e;

    typedef struct packed {
        logic [OP_W-1:0] op_alu;
        logic [TF_W-1:0] op_tf;
        logic            op_se;
        logic            s_mxse;
        logic            w_rb;
        logic [RF_W-1:0] w_rf;
        logic [1:0]      s_mxrb;
        logic            w_dm;
        logic            r_dm;
        logic            branch;
        logic            is_mem;
    } ctrl_t;

    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c       = '0;
        c.op_tf = '1;
        return c;
    endfunction

    state_e          state_q, state_d;
    ctrl_t           cw_q, cw_d, dec;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pc_wr_q;
    logic            dec_ok;
    logic            fetch_ok;
    logic [TF_W-1:0] tf_dec;

    // A PC write in the previous cycle blocks fetch for one cycle so W_PC never repeats.
    assign fetch_ok = bus.im_ready && !pc_wr_q;

    always_comb begin
        dec    = ctrl_nop();
        dec_ok = 1'b1;
        tf_dec = TF_W'({bus.op[2], bus.op[3], bus.op[4]});
        case (bus.ins_type)
            3'b001: begin
                dec.op_alu = bus.op;
                dec.w_rb   = 1'b1;
                dec.s_mxrb = 2'b10;
                if (bus.op == '1)                    dec.w_rf = RF_W'(3'b000);
                else if (bus.op == OP_W'(5'b10000))  dec.w_rf = RF_W'(3'b001);
                else if (bus.op[4:3] == 2'b01)       dec.w_rf = RF_W'(3'b011);
                else if (bus.op[4:3] == 2'b00)       dec.w_rf = RF_W'(3'b100);
                else                                 dec.w_rf = RF_W'(3'b010);
            end
            3'b010: begin
                dec.op_alu = bus.op;
                dec.op_se  = 1'b1;
                dec.s_mxse = 1'b1;
                dec.w_rb   = 1'b1;
                dec.s_mxrb = 2'b10;
            end
            3'b100: begin
                dec.is_mem = 1'b1;
                if (bus.op[4]) begin
                    dec.w_dm = 1'b1;
                end else begin
                    dec.r_dm   = 1'b1;
                    dec.w_rb   = 1'b1;
                    dec.s_mxrb = 2'b01;
                end
            end
            3'b000, 3'b110: begin
                dec.op_alu = OP_W'(5'b10011);
                dec.op_tf  = tf_dec;
                dec.branch = 1'b1;
                dec.s_mxse = (bus.ins_type == 3'b000);
                if (bus.ins_type == 3'b110 && tf_dec == LINK_TF) begin
                    dec.w_rb   = 1'b1;
                    dec.s_mxrb = 2'b00;
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIf;
            cw_q    <= ctrl_nop();
            cnt_q   <= '0;
            pc_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            pc_wr_q <= bus.W_PC;
        end
    end

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIf: if (fetch_ok) state_d = StId;
            StId: begin
                cw_d    = dec_ok ? dec : ctrl_nop();
                state_d = dec_ok ? StEx : StIf;
            end
            StEx: begin
                cnt_d   = '0;
                state_d = cw_q.is_mem ? StMem : StWb;
            end
            StMem: begin
                // dm_ready takes precedence over a timeout on the same cycle.
                if (bus.dm_ready) begin
                    cnt_d   = '0;
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) state_d = StFault;
                end
            end
            StWb:    state_d = StIf;
            StFault: state_d = StFault;
            default: state_d = StIf;
        endcase
    end

    always_comb begin
        bus.OP_ALU  = '0;
        bus.OP_TF   = '1;
        bus.OP_SE   = 1'b0;
        bus.W_PC    = 1'b0;
        bus.S_MXPC  = 1'b0;
        bus.W_IM    = 1'b0;
        bus.W_DM    = 1'b0;
        bus.R_DM    = 1'b0;
        bus.W_RB    = 1'b0;
        bus.W_RF    = '0;
        bus.S_MXRB  = 2'b00;
        bus.S_MXSE  = 1'b0;
        bus.illegal = 1'b0;
        bus.fault   = 1'b0;
        bus.retire  = 1'b0;
        case (state_q)
            StIf: begin
                bus.W_IM = fetch_ok;
                bus.W_PC = fetch_ok;
            end
            StId: bus.illegal = !dec_ok;
            StEx, StMem: begin
                bus.OP_ALU = cw_q.op_alu;
                bus.OP_TF  = cw_q.op_tf;
                bus.OP_SE  = cw_q.op_se;
                bus.S_MXSE = cw_q.s_mxse;
                if (state_q == StMem) begin
                    // A reset arriving mid-access squashes the store immediately.
                    bus.W_DM = cw_q.w_dm && !RESET;
                    bus.R_DM = cw_q.r_dm;
                end
            end
            StWb: begin
                bus.W_RB   = cw_q.w_rb;
                bus.W_RF   = cw_q.w_rf;
                bus.S_MXRB = cw_q.s_mxrb;
                bus.retire = 1'b1;
                if (cw_q.branch && bus.tf_true) begin
                    bus.W_PC   = 1'b1;
                    bus.S_MXPC = 1'b1;
                end
            end
            StFault: bus.fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_unit_control_mc.sv
// Directed bench for unit_control_mc: instruction sequences with hand-computed control outputs.
module tb_unit_control_mc;
    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    unit_control_mc_if bus ();

    unit_control_mc dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    logic [4:0] alu_ops [5] = '{5'b11111, 5'b10000, 5'b01010, 5'b00000, 5'b11000};
    int         alu_rf  [5] = '{0, 1, 3, 4, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Call while in IF; returns at the middle of the following ID cycle.
    task automatic fetch(input logic [2:0] t, input logic [4:0] o);
        bus.im_ready = 1'b1;
        bus.ins_type = t;
        bus.op       = o;
        mid();
        check("if_w_im", 32'(bus.W_IM), 1);
        check("if_w_pc", 32'(bus.W_PC), 1);
        step();
        bus.im_ready = 1'b0;
        mid();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.ins_type = 3'b000;
        bus.op       = 5'b00000;
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
        bus.tf_true  = 1'b0;

        do_reset();
        mid();
        check("rst_w_pc", 32'(bus.W_PC), 0);
        check("rst_w_im", 32'(bus.W_IM), 0);
        check("rst_op_tf", 32'(bus.OP_TF), 7);
        check("rst_fault", 32'(bus.fault), 0);
        check("rst_retire", 32'(bus.retire), 0);
        check("rst_w_dm", 32'(bus.W_DM), 0);

        // ALU reg after a 2-cycle reset, im_ready already high
        bus.im_ready = 1'b1;
        bus.ins_type = 3'b001;
        bus.op       = 5'b00101;
        do_reset();
        mid();
        check("c1_w_im", 32'(bus.W_IM), 1);
        check("c1_w_pc", 32'(bus.W_PC), 1);
        check("c1_s_mxpc", 32'(bus.S_MXPC), 0);
        step(); mid();
        check("c2_illegal", 32'(bus.illegal), 0);
        check("c2_w_pc", 32'(bus.W_PC), 0);
        step(); mid();
        check("c3_op_alu", 32'(bus.OP_ALU), 5);
        check("c3_op_tf", 32'(bus.OP_TF), 7);
        step(); bus.im_ready = 1'b0; mid();
        check("c4_w_rb", 32'(bus.W_RB), 1);
        check("c4_w_rf", 32'(bus.W_RF), 4);
        check("c4_s_mxrb", 32'(bus.S_MXRB), 2);
        check("c4_retire", 32'(bus.retire), 1);
        step(); mid();
        check("c5_retire", 32'(bus.retire), 0);
        check("c5_w_im_wait", 32'(bus.W_IM), 0);

        // W_RF decode corners for ALU reg
        for (int i = 0; i < 5; i++) begin
            step();
            fetch(3'b001, alu_ops[i]);
            step(); mid();
            check("alu_op", 32'(bus.OP_ALU), 32'(alu_ops[i]));
            step(); mid();
            check("alu_w_rf", 32'(bus.W_RF), alu_rf[i]);
        end

        // ALU immediate
        step();
        fetch(3'b010, 5'b00111);
        step(); mid();
        check("imm_op_se", 32'(bus.OP_SE), 1);
        check("imm_s_mxse", 32'(bus.S_MXSE), 1);
        step(); mid();
        check("imm_w_rb", 32'(bus.W_RB), 1);
        check("imm_w_rf", 32'(bus.W_RF), 0);
        check("imm_s_mxrb", 32'(bus.S_MXRB), 2);

        // Store with three wait cycles
        step();
        fetch(3'b100, 5'b10000);
        step(); mid();
        check("st_ex_w_dm", 32'(bus.W_DM), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) bus.dm_ready = 1'b1;
            mid();
            check("st_mem_w_dm", 32'(bus.W_DM), 1);
        end
        step(); bus.dm_ready = 1'b0; mid();
        check("st_wb_w_dm", 32'(bus.W_DM), 0);
        check("st_wb_w_rb", 32'(bus.W_RB), 0);
        check("st_wb_retire", 32'(bus.retire), 1);
        step(); mid();
        check("st_if_retire", 32'(bus.retire), 0);

        // Jump immediate, not taken: TF = {op[2],op[3],op[4]} = 100
        step();
        fetch(3'b000, 5'b00100);
        step(); mid();
        check("ji_op_tf", 32'(bus.OP_TF), 4);
        check("ji_s_mxse", 32'(bus.S_MXSE), 1);
        check("ji_op_alu", 32'(bus.OP_ALU), 32'h13);
        step(); mid();
        check("ji_w_pc", 32'(bus.W_PC), 0);
        check("ji_w_rb", 32'(bus.W_RB), 0);
        check("ji_retire", 32'(bus.retire), 1);

        // Load where dm_ready rises on the last allowed MEM cycle
        step();
        fetch(3'b100, 5'b00000);
        step();
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 15) bus.dm_ready = 1'b1;
            mid();
            if (i == 15) check("ld15_r_dm", 32'(bus.R_DM), 1);
        end
        step(); bus.dm_ready = 1'b0; mid();
        check("ld15_retire", 32'(bus.retire), 1);
        check("ld15_fault", 32'(bus.fault), 0);
        check("ld15_w_rb", 32'(bus.W_RB), 1);
        check("ld15_s_mxrb", 32'(bus.S_MXRB), 1);

        // Load with dm_ready stuck low -> fault after 15 MEM cycles
        step();
        fetch(3'b100, 5'b00000);
        step();
        for (int i = 1; i <= 15; i++) begin
            step(); mid();
            if (i == 15) begin
                check("to_r_dm", 32'(bus.R_DM), 1);
                check("to_fault_early", 32'(bus.fault), 0);
            end
        end
        step(); bus.im_ready = 1'b1; bus.dm_ready = 1'b1; mid();
        check("to_fault", 32'(bus.fault), 1);
        check("to_r_dm_off", 32'(bus.R_DM), 0);
        check("to_w_rb", 32'(bus.W_RB), 0);
        for (int i = 0; i < 3; i++) begin
            step(); mid();
            check("to_fault_hold", 32'(bus.fault), 1);
            check("to_w_im", 32'(bus.W_IM), 0);
            check("to_w_pc", 32'(bus.W_PC), 0);
        end
        bus.im_ready = 1'b0;
        bus.dm_ready = 1'b0;
        do_reset();
        mid();
        check("to_fault_clr", 32'(bus.fault), 0);

        // Jump reg with link TF (op=11000 -> TF=011), taken then not taken
        bus.tf_true = 1'b1;
        step();
        fetch(3'b110, 5'b11000);
        check("jr_illegal", 32'(bus.illegal), 0);
        step(); mid();
        check("jr_op_tf", 32'(bus.OP_TF), 3);
        check("jr_s_mxse", 32'(bus.S_MXSE), 0);
        step(); mid();
        check("jr_w_pc", 32'(bus.W_PC), 1);
        check("jr_s_mxpc", 32'(bus.S_MXPC), 1);
        check("jr_w_rb", 32'(bus.W_RB), 1);
        check("jr_s_mxrb", 32'(bus.S_MXRB), 0);
        step(); bus.im_ready = 1'b1; bus.tf_true = 1'b0; mid();
        check("jr_no_b2b_w_pc", 32'(bus.W_PC), 0);
        check("jr_no_b2b_w_im", 32'(bus.W_IM), 0);
        step(); mid();
        check("jr2_w_im", 32'(bus.W_IM), 1);
        step(); bus.im_ready = 1'b0;
        step();
        step(); mid();
        check("jr2_w_pc", 32'(bus.W_PC), 0);
        check("jr2_s_mxpc", 32'(bus.S_MXPC), 0);
        check("jr2_w_rb", 32'(bus.W_RB), 1);
        check("jr2_retire", 32'(bus.retire), 1);

        // Undefined type 111
        step();
        fetch(3'b111, 5'b00000);
        check("il_illegal", 32'(bus.illegal), 1);
        check("il_w_rb", 32'(bus.W_RB), 0);
        check("il_w_pc", 32'(bus.W_PC), 0);
        step(); bus.im_ready = 1'b1; mid();
        check("il_back_if", 32'(bus.W_IM), 1);
        check("il_pulse_end", 32'(bus.illegal), 0);
        check("il_retire", 32'(bus.retire), 0);
        step(); bus.im_ready = 1'b0;

        // Reset during the second MEM wait cycle of a store
        step();
        fetch(3'b100, 5'b10000);
        step();
        step(); mid();
        check("rm_mem1_w_dm", 32'(bus.W_DM), 1);
        step(); rst = 1'b1; mid();
        check("rm_mem2_w_dm", 32'(bus.W_DM), 0);
        step(); rst = 1'b0; bus.im_ready = 1'b1; mid();
        check("rm_after_w_dm", 32'(bus.W_DM), 0);
        check("rm_after_if", 32'(bus.W_IM), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
